// File: rtl/count_compare_pkg.sv
// Shared register map, CTRL field layout, bus FSM encoding and byte-merge helper
// for the count/compare interrupt unit.
package count_compare_pkg;

  localparam logic [2:0] CCI_CTRL   = 3'd0;
  localparam logic [2:0] CCI_CMP0   = 3'd1;
  localparam logic [2:0] CCI_CMP1   = 3'd2;
  localparam logic [2:0] CCI_CMP2   = 3'd3;
  localparam logic [2:0] CCI_STATUS = 3'd4;
  localparam logic [2:0] CCI_STEP   = 3'd5;

  localparam int EN_LSB   = 0;
  localparam int IE_LSB   = 4;
  localparam int AUTO_LSB = 8;

  localparam int NCHAN = 3;

  localparam logic [0:0] FSM_IDLE = 1'b0;
  localparam logic [0:0] FSM_ACK  = 1'b1;

  // Replace the bytes of old_v selected by sel with the matching bytes of new_v.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/count_compare_chan.sv
// One compare channel: compare register, rising-edge match detect, optional
// auto-advance by the shared step, and the sticky pending bit with W1C.
module count_compare_chan
  import count_compare_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [BITS-1:0] count_i,
  input  logic [BITS-1:0] step_i,
  input  logic            en_i,
  input  logic            ie_i,
  input  logic            auto_i,
  input  logic            wr_i,
  input  logic [3:0]      wr_sel_i,
  input  logic [31:0]     wr_dat_i,
  input  logic            w1c_i,
  output logic [BITS-1:0] cmp_o,
  output logic            pend_o,
  output logic            irq_o
);

  logic [BITS-1:0] cmp_q;
  logic [BITS-1:0] cmp_d;
  logic            hit_q;
  logic            hit_d;
  logic            pend_q;
  logic            pend_d;
  logic            evt_s;
  logic [BITS-1:0] adv_s;
  logic [31:0]     merged_s;

  // Bus bytes written this cycle override the advanced value; untouched bytes keep it.
  always_comb begin
    hit_d = en_i & (count_i == cmp_q);
    evt_s = hit_d & ~hit_q;
    if (evt_s && auto_i) begin
      adv_s = cmp_q + step_i;
    end else begin
      adv_s = cmp_q;
    end
    merged_s = byte_merge(32'(adv_s), wr_dat_i, wr_sel_i);
    if (wr_i) begin
      cmp_d = merged_s[BITS-1:0];
    end else begin
      cmp_d = adv_s;
    end
    if (evt_s) begin
      pend_d = 1'b1;
    end else if (w1c_i) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmp_q  <= '0;
      hit_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cmp_q  <= cmp_d;
      hit_q  <= hit_d;
      pend_q <= pend_d;
    end
  end

  assign cmp_o  = cmp_q;
  assign pend_o = pend_q;
  assign irq_o  = pend_q & ie_i;

endmodule

// File: rtl/count_compare_irq.sv
// Wishbone-programmable compare/interrupt unit: CTRL and STEP registers, the
// two-state bus FSM, the registered read mux and three compare channels.
module count_compare_irq
  import count_compare_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [BITS-1:0] count_i,
  output logic [2:0]      irq
);

  logic [0:0]      state_q;
  logic [0:0]      state_d;
  logic            ack_q;
  logic            ack_d;
  logic [31:0]     dat_q;
  logic [31:0]     dat_d;
  logic [2:0]      en_q;
  logic [2:0]      en_d;
  logic [2:0]      ie_q;
  logic [2:0]      ie_d;
  logic [2:0]      auto_q;
  logic [2:0]      auto_d;
  logic [BITS-1:0] step_q;
  logic [BITS-1:0] step_d;

  logic            req_s;
  logic            wr_s;
  logic            rd_s;
  logic [2:0]      idx_s;
  logic [2:0]      chan_wr_s;
  logic [2:0]      w1c_s;
  logic [31:0]     rd_mux_s;
  logic [31:0]     ctrl_rd_s;
  logic [31:0]     step_merge_s;
  logic [BITS-1:0] cmp_s [NCHAN];
  logic [2:0]      pend_s;
  logic            unused_s;

  assign unused_s = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

  assign req_s = (state_q == FSM_IDLE) & wbs_cyc_i & wbs_stb_i;
  assign wr_s  = req_s & wbs_we_i;
  assign rd_s  = req_s & ~wbs_we_i;
  assign idx_s = wbs_adr_i[4:2];

  always_comb begin
    case (state_q)
      FSM_IDLE: state_d = req_s ? FSM_ACK : FSM_IDLE;
      FSM_ACK:  state_d = FSM_IDLE;
      default:  state_d = FSM_IDLE;
    endcase
    ack_d = req_s;
  end

  // Per-channel write strobes; W1C only looks at byte lane 0.
  always_comb begin
    chan_wr_s = 3'b000;
    w1c_s     = 3'b000;
    if (wr_s) begin
      case (idx_s)
        CCI_CMP0:   chan_wr_s = 3'b001;
        CCI_CMP1:   chan_wr_s = 3'b010;
        CCI_CMP2:   chan_wr_s = 3'b100;
        CCI_STATUS: w1c_s = wbs_sel_i[0] ? wbs_dat_i[2:0] : 3'b000;
        default: begin
          chan_wr_s = 3'b000;
          w1c_s     = 3'b000;
        end
      endcase
    end else begin
      chan_wr_s = 3'b000;
      w1c_s     = 3'b000;
    end
  end

  always_comb begin
    en_d         = en_q;
    ie_d         = ie_q;
    auto_d       = auto_q;
    step_d       = step_q;
    step_merge_s = byte_merge(32'(step_q), wbs_dat_i, wbs_sel_i);
    if (wr_s && (idx_s == CCI_CTRL)) begin
      if (wbs_sel_i[0]) begin
        en_d = wbs_dat_i[EN_LSB +: 3];
        ie_d = wbs_dat_i[IE_LSB +: 3];
      end else begin
        en_d = en_q;
        ie_d = ie_q;
      end
      if (wbs_sel_i[1]) begin
        auto_d = wbs_dat_i[AUTO_LSB +: 3];
      end else begin
        auto_d = auto_q;
      end
    end else if (wr_s && (idx_s == CCI_STEP)) begin
      step_d = step_merge_s[BITS-1:0];
    end else begin
      step_d = step_q;
    end
  end

  // Read data reflects register state before this cycle's events land.
  always_comb begin
    ctrl_rd_s                   = 32'd0;
    ctrl_rd_s[EN_LSB +: 3]      = en_q;
    ctrl_rd_s[IE_LSB +: 3]      = ie_q;
    ctrl_rd_s[AUTO_LSB +: 3]    = auto_q;
    case (idx_s)
      CCI_CTRL:   rd_mux_s = ctrl_rd_s;
      CCI_CMP0:   rd_mux_s = 32'(cmp_s[0]);
      CCI_CMP1:   rd_mux_s = 32'(cmp_s[1]);
      CCI_CMP2:   rd_mux_s = 32'(cmp_s[2]);
      CCI_STATUS: rd_mux_s = {29'd0, pend_s};
      CCI_STEP:   rd_mux_s = 32'(step_q);
      default:    rd_mux_s = 32'd0;
    endcase
    if (rd_s) begin
      dat_d = rd_mux_s;
    end else begin
      dat_d = dat_q;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= FSM_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      en_q    <= 3'b000;
      ie_q    <= 3'b000;
      auto_q  <= 3'b000;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      auto_q  <= auto_d;
      step_q  <= step_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  for (genvar k = 0; k < NCHAN; k++) begin : g_chan
    count_compare_chan #(
      .BITS(BITS)
    ) u_chan (
      .clk_i    (wb_clk_i),
      .rst_i    (wb_rst_i),
      .count_i  (count_i),
      .step_i   (step_q),
      .en_i     (en_q[k]),
      .ie_i     (ie_q[k]),
      .auto_i   (auto_q[k]),
      .wr_i     (chan_wr_s[k]),
      .wr_sel_i (wbs_sel_i),
      .wr_dat_i (wbs_dat_i),
      .w1c_i    (w1c_s[k]),
      .cmp_o    (cmp_s[k]),
      .pend_o   (pend_s[k]),
      .irq_o    (irq[k])
    );
  end

endmodule

// File: tb/tb_count_compare_irq.sv
// Self-checking bench for count_compare_irq: directed plan steps followed by a
// randomized phase, all checked against a cycle-level behavioural model.
module tb_count_compare_irq;

  localparam int BITS = 32;
  localparam logic [2:0] I_CTRL   = 3'd0;
  localparam logic [2:0] I_CMP0   = 3'd1;
  localparam logic [2:0] I_CMP1   = 3'd2;
  localparam logic [2:0] I_CMP2   = 3'd3;
  localparam logic [2:0] I_STATUS = 3'd4;
  localparam logic [2:0] I_STEP   = 3'd5;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  sel   = 4'h0;
  logic [31:0] adr   = 32'd0;
  logic [31:0] wdat  = 32'd0;
  logic [31:0] count = 32'd0;
  logic        ack;
  logic [31:0] rdat;
  logic [2:0]  irq;

  always #5 clk = ~clk;

  count_compare_irq #(.BITS(BITS)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .count_i   (count),
    .irq       (irq)
  );

  // Behavioural model state
  logic [31:0] m_cmp [3];
  logic [31:0] m_step;
  logic [2:0]  m_en, m_ie, m_auto, m_pend, m_seen;
  logic        m_busy, m_ack;
  logic [31:0] m_dat;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_cmp[k] = 32'd0;
    m_step = 32'd0;
    m_en = 3'b000; m_ie = 3'b000; m_auto = 3'b000; m_pend = 3'b000; m_seen = 3'b000;
    m_busy = 1'b0; m_ack = 1'b0; m_dat = 32'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] idx);
    case (idx)
      I_CTRL:   return {21'd0, m_auto, 1'b0, m_ie, 1'b0, m_en};
      I_CMP0:   return m_cmp[0];
      I_CMP1:   return m_cmp[1];
      I_CMP2:   return m_cmp[2];
      I_STATUS: return {29'd0, m_pend};
      I_STEP:   return m_step;
      default:  return 32'd0;
    endcase
  endfunction

  // One clock: predict from the current inputs, advance, then compare outputs.
  task automatic tick();
    logic [31:0] ncmp [3];
    logic [2:0]  npend, nseen;
    logic        req;
    logic [2:0]  idx;
    logic [31:0] rd;
    idx = adr[4:2];
    req = cyc && stb && !m_busy;
    rd  = model_read(idx);
    for (int k = 0; k < 3; k++) begin
      logic hit;
      hit      = m_en[k] && (count == m_cmp[k]);
      nseen[k] = hit;
      ncmp[k]  = m_cmp[k];
      npend[k] = m_pend[k];
      if (hit && !m_seen[k]) begin
        npend[k] = 1'b1;
        if (m_auto[k]) ncmp[k] = m_cmp[k] + m_step;
      end else if (req && we && idx == I_STATUS && sel[0] && wdat[k]) begin
        npend[k] = 1'b0;
      end
      if (req && we && idx == 3'(k + 1))
        for (int b = 0; b < 4; b++) if (sel[b]) ncmp[k][8*b +: 8] = wdat[8*b +: 8];
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (req && we && idx == I_CTRL) begin
        if (sel[0]) begin m_en = wdat[2:0]; m_ie = wdat[6:4]; end
        if (sel[1]) m_auto = wdat[10:8];
      end
      if (req && we && idx == I_STEP)
        for (int b = 0; b < 4; b++) if (sel[b]) m_step[8*b +: 8] = wdat[8*b +: 8];
      for (int k = 0; k < 3; k++) m_cmp[k] = ncmp[k];
      m_pend = npend;
      m_seen = nseen;
      m_ack  = req;
      m_busy = req;
      if (req && !we) m_dat = rd;
    end
    #1;
    check("ack", 32'(ack), 32'(m_ack));
    check("rdata", rdat, m_dat);
    check("irq", 32'(irq), 32'(m_pend & m_ie));
  endtask

  task automatic wb_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {27'd0, idx, 2'b00}; wdat = d; sel = s;
    tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic wb_read(input logic [2:0] idx, input bit chk, input logic [31:0] exp);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {27'd0, idx, 2'b00};
    tick();
    if (chk) check("read_const", rdat, exp);
    cyc = 1'b0; stb = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();

    // Reset state and every index reads zero
    do_reset();
    for (int i = 0; i < 8; i++) wb_read(3'(i), 1'b1, 32'd0);

    // Counter ramp on channel 0
    wb_write(I_CMP0, 32'h10, 4'hF);
    wb_write(I_CTRL, 32'h011, 4'hF);
    for (int c = 0; c <= 20; c++) begin
      count = 32'(c);
      tick();
      if (c == 15) check("ramp_before", 32'(irq), 32'd0);
      if (c == 16) check("ramp_rise", 32'(irq), 32'd1);
    end
    wb_read(I_STATUS, 1'b1, 32'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {27'd0, I_STATUS, 2'b00}; wdat = 32'd1; sel = 4'h1;
    tick();
    check("w1c_clear", 32'(irq), 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();

    // Periodic mode on channel 1
    wb_write(I_CMP1, 32'h20, 4'hF);
    wb_write(I_STEP, 32'h20, 4'hF);
    wb_write(I_CTRL, 32'h222, 4'hF);
    for (int c = 24; c <= 104; c++) begin
      count = 32'(c);
      tick();
      if (c == 32 || c == 64 || c == 96) check("periodic_evt", 32'(irq), 32'd2);
      if (c[4:0] == 5'h04 && c > 32) wb_write(I_STATUS, 32'h2, 4'h1);
    end
    wb_read(I_CMP1, 1'b1, 32'h80);

    // Held count on channel 2
    count = 32'd0;
    wb_write(I_CMP2, 32'h5, 4'hF);
    wb_write(I_CTRL, 32'h044, 4'hF);
    count = 32'd5;
    for (int i = 0; i < 4; i++) tick();
    check("held_one", 32'(irq), 32'd4);
    wb_write(I_STATUS, 32'h4, 4'h1);
    for (int i = 0; i < 3; i++) tick();
    check("held_w1c", 32'(irq), 32'd0);
    count = 32'd6; tick();
    count = 32'd5; tick();
    check("held_second", 32'(irq), 32'd4);

    // Collision: event and W1C on channel 0 in the same cycle
    wb_write(I_STATUS, 32'h7, 4'h1);
    wb_write(I_CMP0, 32'h30, 4'hF);
    wb_write(I_CTRL, 32'h011, 4'hF);
    count = 32'h2F; tick();
    count = 32'h30;
    wb_write(I_STATUS, 32'h1, 4'h1);
    check("collide_pend", 32'(irq[0]), 32'd1);

    // Collision: byte write to CMP1 during auto-advance
    wb_write(I_CMP1, 32'h1122_3344, 4'hF);
    wb_write(I_STEP, 32'h0101_0101, 4'hF);
    wb_write(I_CTRL, 32'h222, 4'hF);
    count = 32'h1122_3343; tick();
    count = 32'h1122_3344;
    wb_write(I_CMP1, 32'h0000_00AA, 4'b0001);
    wb_read(I_CMP1, 1'b1, 32'h1223_34AA);

    // Reset in the ACK cycle with an interrupt pending
    check("irq_before_rst", 32'(irq[1]), 32'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {27'd0, I_STATUS, 2'b00};
    tick();
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    tick();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) wb_read(3'(i), 1'b1, 32'd0);

    // Randomized phase, starting near the counter wrap point
    count = 32'hFFFF_FFE0;
    for (int n = 0; n < 400; n++) begin
      int unsigned pick;
      logic [2:0]  idx;
      logic [31:0] d;
      pick = $urandom_range(0, 99);
      idx  = 3'($urandom_range(0, 7));
      if (pick < 20) begin
        case (idx)
          I_CMP0, I_CMP1, I_CMP2: d = count + 32'($urandom_range(0, 24));
          I_STEP:                 d = 32'($urandom_range(0, 6));
          default:                d = $urandom;
        endcase
        wb_write(idx, d, 4'($urandom_range(0, 15)));
      end else if (pick < 30) begin
        wb_read(idx, 1'b0, 32'd0);
      end else begin
        count = count + 32'($urandom_range(0, 2));
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/count_compare_irq.md
# count_compare_irq

Wishbone-programmable compare/interrupt unit that sits directly downstream of the user-area counter. It consumes the free-running counter value and compares it against three programmable compare registers. It raises sticky, individually maskable interrupts on the user `irq[2:0]` lines, which the counter block currently ties low. Compare registers can optionally auto-advance by a shared step, giving periodic interrupts without firmware reloads.

## Interface
- `BITS`, 32, width of the counter value and the compare registers (≤32).
- `wb_clk_i`  in  1  single clock.
- `wb_rst_i`  in  1  reset; synchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic strobes.
- `wbs_sel_i`  in  4  byte enables.
- `wbs_adr_i`  in  32  byte address; only `[4:2]` decoded.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  registered read data.
- `count_i`  in  BITS  counter value from the upstream counter, same clock.
- `irq`  out  3  `irq[k] = pend[k] & ie[k]`.

## Operation
- Register map (word index `adr[4:2]`):
  - 0 CTRL: `[2:0]` en, `[6:4]` ie, `[10:8]` auto.
  - 1–3 CMP0–CMP2.
  - 4 STATUS: `[2:0]` pend, W1C.
  - 5 STEP.
  - 6–7 read 0, writes ignored.
- Bits above BITS in CMP and STEP read 0. Unused CTRL bits read 0.
- CMP, STEP and CTRL writes honour `wbs_sel_i` per byte. STATUS W1C uses byte 0 only.
- Match: `hit[k] = en[k] & (count_i == cmp[k])`. `hit_q[k]` is registered every cycle.
  - Event when `hit[k] & ~hit_q[k]` (rising edge only). A count held equal gives one event.
- On event: `pend[k] <= 1`. If `auto[k]`, `cmp[k] <= cmp[k] + STEP` mod 2^BITS.
- Clearing `en[k]` does not clear `pend[k]`.
- Simultaneous event and W1C on the same `k`: set wins, pend stays 1.
- Simultaneous auto-advance and Wishbone write to `CMP[k]`: Wishbone write wins for written bytes. Unwritten bytes take the advanced value.
- STEP = 0 with auto: cmp unchanged, and the edge rule prevents repeat events.
- Wishbone FSM, states IDLE and ACK:
  - IDLE: `cyc & stb` → perform write or latch read data → ACK.
  - ACK: `ack=1` for one cycle → IDLE, unconditionally.
  - A strobe still asserted in the IDLE cycle after ACK starts a new transaction. Maximum throughput is one access per 2 cycles.
- Read data is sampled in the IDLE→ACK cycle and reflects register state before any same-cycle event.

## Timing
- Reset values:
  - Outputs: `wbs_ack_o=0`, `wbs_dat_o=0`, `irq=0`.
  - Internal state: CTRL, CMPx, STEP, pend and `hit_q` all 0.
- Request presented in cycle t → `wbs_ack_o=1` in t+1, 0 in t+2. Write takes effect at the edge ending cycle t.
- `count_i == cmp` in cycle t → `pend` and `irq` high in t+1. Advanced cmp is visible in t+1.
- W1C in cycle t → `irq` low in t+1 unless re-set.
- Reset asserted mid-transaction: ack is suppressed and the FSM returns to IDLE; no partial write occurs.
- Reset overrides all other events.

## Structure
- Package `count_compare_pkg`:
  - Register index localparams: `CCI_CTRL`, `CCI_CMP0..2`, `CCI_STATUS`, `CCI_STEP`.
  - CTRL field offsets: `EN_LSB=0`, `IE_LSB=4`, `AUTO_LSB=8`.
  - `FSM_IDLE` / `FSM_ACK` state encoding.
- Sub-module `count_compare_chan`, instantiated 3×.
  - Contents: holds cmp, `hit_q` and pend; performs compare, edge detect, auto-advance and W1C/set priority.
  - Inputs: byte-write bus, W1C strobe, and en/ie/auto bits.
- Top level holds CTRL, STEP, the Wishbone FSM and the read mux.

## Test plan
- Reset, then read all 8 indices → every read 0, `irq=0`, ack exactly one cycle after each strobe.
- Counter ramp: CMP0=0x10, CTRL=0x011, ramp `count_i` from 0 → `irq[0]` rises the cycle after `count_i=0x10`; STATUS reads 0x1; W1C 0x1 → `irq[0]` low next cycle.
- Periodic mode: CMP1=0x20, STEP=0x20, CTRL=0x222 → events at 0x20, 0x40, 0x60; CMP1 reads 0x80 after the third; pend is re-set after each W1C.
- Held count: `count_i` held at 0x5 with CMP2=0x5, en2 set → exactly one event. W1C during hold → pend stays 0. Move `count_i` away and back → second event.
- Collision: W1C pend0 in the same cycle as a new CMP0 match → pend0 stays 1. Byte write `sel=4'b0001` to CMP1 during auto-advance → low byte = written value, upper bytes = advanced value.
- Reset asserted in the ACK cycle and during a pending IRQ → ack drops and `irq=0` in the next cycle; all registers read 0 afterwards.
